// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter that shares one 12-to-16-bit immediate extender between
// a fetch-stage requester (A) and an execute-stage requester (B). The result
// sits in a one-entry output register with a valid/ready handshake.
module imm_ext_arbiter #(
  parameter int unsigned IMM_W = 12,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [IMM_W-1:0] a_imm,
  input  logic             a_zext,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [IMM_W-1:0] b_imm,
  input  logic             b_zext,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_src
);

  // Upper bits are copies of the immediate's MSB unless zero-extension is requested.
  function automatic logic [OUT_W-1:0] extend(input logic [IMM_W-1:0] imm, input logic zext);
    extend = {{(OUT_W - IMM_W){imm[IMM_W-1] & ~zext}}, imm};
  endfunction

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_src_q;
  logic             last_grant_q;  // 0 = A, 1 = B
  logic             can_accept;
  logic             grant_a;
  logic             grant_b;
  logic             accept;
  logic [OUT_W-1:0] ext_data;

  // Grant selection and handshake; readies are forced low while in reset.
  always_comb begin
    can_accept = ~out_valid_q | out_ready;
    grant_a    = a_valid & (~b_valid | last_grant_q);
    grant_b    = b_valid & (~a_valid | ~last_grant_q);
    a_ready    = rst_n & can_accept & grant_a;
    b_ready    = rst_n & can_accept & grant_b;
    accept     = a_ready | b_ready;
    ext_data   = grant_b ? extend(b_imm, b_zext) : extend(a_imm, a_zext);
  end

  // Output register and round-robin pointer; pointer moves only on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= ext_data;
      out_src_q    <= grant_b;
      last_grant_q <= grant_b;
    end else if (out_valid_q && out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
